// File: rtl/bridge_pkg.sv
// Shared definitions for the bridge link arbiter: FSM states, frame layout
// {mode, data, addr} and mode encodings.
package bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_SHIFT,
    ST_RESP
  } state_t;

  localparam logic MODE_WR = 1'b1;
  localparam logic MODE_RD = 1'b0;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_ADDR_WIDTH   = 12;
  localparam int DEF_RESP_TIMEOUT = 65535;

  // The frame carries one address bit fewer than the bus, so the data field
  // starts at ADDR_WIDTH-1 and the mode bit sits on top of the data field.
  function automatic int frame_data_lsb(input int addr_width);
    return addr_width - 1;
  endfunction

  function automatic int frame_mode_bit(input int addr_width, input int data_width);
    return addr_width - 1 + data_width;
  endfunction

  localparam int ADDR_LSB = 0;
  localparam int DATA_LSB = frame_data_lsb(DEF_ADDR_WIDTH);
  localparam int MODE_BIT = frame_mode_bit(DEF_ADDR_WIDTH, DEF_DATA_WIDTH);

endpackage

// File: rtl/bridge_link_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo NUM_REQ.
module rr_arbiter
  import bridge_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr) + i) % NUM_REQ;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/bridge_link_arbiter.sv
// Shares one bridge UART link between NUM_REQ requesters, round-robin.
// Optional read-response timeout enabled by defining BRIDGE_RESP_TIMEOUT_EN.
module bridge_link_arbiter
  import bridge_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int FRAME_WIDTH  = DATA_WIDTH + ADDR_WIDTH,
  parameter int RESP_TIMEOUT = DEF_RESP_TIMEOUT
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_mode,
  input  logic [NUM_REQ*(ADDR_WIDTH-1)-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               req_ack,
  output logic [NUM_REQ-1:0]               resp_valid,
  output logic [DATA_WIDTH-1:0]            resp_data,
  output logic                             resp_err,
  output logic [FRAME_WIDTH-1:0]           u_din,
  output logic                             u_en,
  input  logic                             u_tx_busy,
  input  logic                             u_rx_ready,
  input  logic [DATA_WIDTH-1:0]            u_dout,
  output logic                             stray_rx
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW    = ADDR_WIDTH - 1;
  localparam int D_LSB = frame_data_lsb(ADDR_WIDTH);
  localparam int M_BIT = frame_mode_bit(ADDR_WIDTH, DATA_WIDTH);

  state_t               state, next_state;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     idx;
  logic                 mode;
  logic                 rx_ready_p1;
  logic                 rx_rise;
  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_any;
  logic                 grant_mode;
  logic [FRAME_WIDTH-1:0] frame;
  logic [NUM_REQ-1:0]   ack_vec;
  logic                 take, done_wr, done_rd, done_to;
  logic                 timeout_hit;

  // A requester whose ack is visible this cycle has not yet dropped req_valid,
  // so it must not be re-granted from the stale request.
  assign eligible   = req_valid & ~req_ack;
  assign rx_rise    = u_rx_ready & ~rx_ready_p1;
  assign grant_mode = |(req_mode & grant);
  assign ack_vec    = NUM_REQ'(1) << idx;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req   (eligible),
    .ptr   (ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  always_comb begin
    frame = '0;
    frame[ADDR_LSB +: AW] = req_addr[grant_idx*AW +: AW];
    if (grant_mode == MODE_WR)
      frame[D_LSB +: DATA_WIDTH] = req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    frame[M_BIT] = grant_mode;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    take       = 1'b0;
    done_wr    = 1'b0;
    done_rd    = 1'b0;
    done_to    = 1'b0;
    case (state)
      ST_IDLE:  if (grant_any && !u_tx_busy) begin
                  take       = 1'b1;
                  next_state = ST_LOAD;
                end
      ST_LOAD:  next_state = ST_START;
      ST_START: if (u_tx_busy) next_state = ST_SHIFT;
      ST_SHIFT: if (!u_tx_busy) begin
                  if (mode == MODE_WR) begin
                    done_wr    = 1'b1;
                    next_state = ST_IDLE;
                  end else begin
                    next_state = ST_RESP;
                  end
                end
      ST_RESP:  if (rx_rise) begin
                  done_rd    = 1'b1;
                  next_state = ST_IDLE;
                end else if (timeout_hit) begin
                  done_to    = 1'b1;
                  next_state = ST_IDLE;
                end
      default:  next_state = ST_IDLE;
    endcase
  end

  // Transaction context is only meaningful while a grant is live, so it is
  // loaded at grant time and never reset.
  always_ff @(posedge clk) begin
    if (take) begin
      idx  <= grant_idx;
      mode <= grant_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      rx_ready_p1 <= 1'b0;
      u_en        <= 1'b0;
      u_din       <= '0;
      req_ack     <= '0;
      resp_valid  <= '0;
      resp_data   <= '0;
      stray_rx    <= 1'b0;
    end else begin
      rx_ready_p1 <= u_rx_ready;
      u_en        <= take;
      req_ack     <= '0;
      resp_valid  <= '0;
      if (take) begin
        u_din <= frame;
        ptr   <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (done_wr)
        req_ack <= ack_vec;
      if (done_rd) begin
        req_ack    <= ack_vec;
        resp_valid <= ack_vec;
        resp_data  <= u_dout;
      end else if (done_to) begin
        req_ack    <= ack_vec;
        resp_valid <= ack_vec;
        resp_data  <= '1;
      end
      if (rx_rise && state != ST_RESP)
        stray_rx <= 1'b1;
    end
  end

`ifdef BRIDGE_RESP_TIMEOUT_EN
  localparam int TW = $clog2(RESP_TIMEOUT + 1);
  logic [TW-1:0] resp_cnt;

  // Counter restarts whenever RESP is not active, i.e. zero on RESP entry.
  always_ff @(posedge clk) begin
    if (rst || state != ST_RESP) resp_cnt <= '0;
    else                         resp_cnt <= resp_cnt + 1'b1;
  end

  assign timeout_hit = (state == ST_RESP) && (resp_cnt == TW'(RESP_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) resp_err <= 1'b0;
    else     resp_err <= done_to;
  end
`else
  // Never expires: RESP waits for the response indefinitely.
  assign timeout_hit = (RESP_TIMEOUT < 0);
  assign resp_err    = 1'b0;
`endif

endmodule

// File: doc/bridge_link_arbiter.md
Name: bridge_link_arbiter

Overview:
- Shares one bridge UART link (TX frame path plus RX response path) between NUM_REQ bridge requesters.
- Each requester is a bus-bridge-style slave controller wanting to send write or read frames to the remote system.
- Grants the link round-robin, loads and launches each frame, and for reads holds the link until the single-byte response returns.
- Routes the response back to the owning requester. Sits between the requester controllers and the single uart instance.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_WIDTH, 8, data byte width.
- ADDR_WIDTH, 12, bus address width; frames carry addr[ADDR_WIDTH-2:0].
- FRAME_WIDTH, DATA_WIDTH+ADDR_WIDTH, TX frame {mode, data, addr[ADDR_WIDTH-2:0]}.
- RESP_TIMEOUT, 65535, cycles to wait for a read response (used only with the timeout feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  request pending per requester; held until req_ack
- req_mode  in  NUM_REQ  1=write, 0=read
- req_addr  in  NUM_REQ*(ADDR_WIDTH-1)  packed frame addresses
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
- req_ack  out  NUM_REQ  one-cycle pulse: frame launched (write) or completed (read)
- resp_valid  out  NUM_REQ  one-cycle pulse with read data
- resp_data  out  DATA_WIDTH  read data, valid with resp_valid
- resp_err  out  1  read timed out, valid with resp_valid
- u_din  out  FRAME_WIDTH  frame to uart
- u_en  out  1  one-cycle transmit strobe
- u_tx_busy  in  1  uart TX busy
- u_rx_ready  in  1  uart RX byte ready (level)
- u_dout  in  DATA_WIDTH  uart RX byte
- stray_rx  out  1  sticky: RX byte arrived with no read outstanding

Behaviour:
- Reset:
  - All outputs 0; state IDLE; round-robin pointer 0.
  - Reset mid-transaction abandons it with no ack; the requester must re-request.
- States:
  - IDLE: if any req_valid and u_tx_busy=0, pick the first requester at or after the pointer, latch its index/mode/addr/data, go to LOAD.
  - LOAD: u_din <= {mode, mode?wdata:0, addr}; u_en=1 for exactly this cycle; go to START.
  - START: wait for u_tx_busy=1, then go to SHIFT.
  - SHIFT: wait for u_tx_busy=0.
    - Write: pulse req_ack[idx], go to IDLE.
    - Read: go to RESP.
  - RESP: on a rising edge of u_rx_ready (registered previous value), capture u_dout, pulse resp_valid[idx] and req_ack[idx] in the same cycle, go to IDLE.
- Round-robin pointer advances to idx+1 (mod NUM_REQ) when the grant is taken in IDLE.
- Latency:
  - Grant to u_en: 1 cycle (IDLE to LOAD).
  - Read response: resp_valid 1 cycle after the u_rx_ready rising edge.
- Only one transaction in flight; no pipelining across requesters.
- req_valid dropped after grant: ignored, the latched transaction completes.
- req_ack is never pulsed to a requester that was not granted.
- RX edge outside RESP: byte dropped, stray_rx set; cleared only by reset.
- u_tx_busy high in IDLE (uart still finishing): hold in IDLE.
- Simultaneous req_valid from all requesters: strict rotation, so each is served once per NUM_REQ grants.
- resp_data holds its last value between pulses.

Optional Feature:
- Macro: BRIDGE_RESP_TIMEOUT_EN.
- Defined:
  - A counter resets on entry to RESP and increments each RESP cycle.
  - When it reaches RESP_TIMEOUT: pulse resp_valid[idx] and req_ack[idx] with resp_data={DATA_WIDTH{1'b1}} and resp_err=1, then go to IDLE.
  - A response edge arriving in the same cycle as expiry wins (data, resp_err=0).
- Not defined: RESP waits indefinitely; resp_err tied 0; no counter logic.

Decomposition:
- Shared package bridge_pkg:
  - FSM state encoding (IDLE, LOAD, START, SHIFT, RESP).
  - Frame field offsets/widths (MODE_BIT, DATA_LSB, ADDR_LSB).
  - Mode constants MODE_WR=1, MODE_RD=0.
  - Default timeout.
- One sub-module: rr_arbiter. Inputs req vector and pointer; outputs one-hot grant and index. Purely combinational priority rotate.

Test Plan:
- Single write, req 0 addr 0x123 data 0xA5 -> u_en one cycle with u_din={1,0xA5,0x123}; req_ack[0] after u_tx_busy falls.
- Read, req 1 addr 0x045; model returns 0x3C -> u_din={0,0x00,0x045}; resp_valid[1]=1, resp_data=0x3C, resp_err=0, resp_valid[0] never asserts.
- Both requesters hold writes continuously for 6 grants -> grant order 0,1,0,1,0,1; no back-to-back u_en while u_tx_busy=1.
- RX byte 0x77 injected during IDLE -> no resp_valid; stray_rx=1 until rst.
- With BRIDGE_RESP_TIMEOUT_EN, RESP_TIMEOUT=100, read with no response -> resp_valid after 100 RESP cycles with resp_data=0xFF and resp_err=1; next request then served.
- rst asserted in SHIFT of a read -> next cycle all outputs 0, state IDLE; no req_ack for the aborted read.
